// File: rtl/request_encoder_16to4.sv
// Latching 16-to-4 priority encoder: accumulates request strobes into a pending
// register and presents one granted index at a time under a valid/ack handshake.
module request_encoder_16to4 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Enable,
  input  logic [15:0] Request_In,
  input  logic [15:0] Mask,
  input  logic        Clear_All,
  input  logic        Ack,
  output logic [3:0]  Encoder_Output,
  output logic        Valid,
  output logic [15:0] Pending
);

  localparam int N = 16;
  localparam int W = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   enc_q, enc_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic [N-1:0]   elig;
  logic [N-1:0]   clr;
  logic           ack_fire;
  logic [W-1:0]   start;
  logic [W-1:0]   idx;
  logic [W-1:0]   win_idx;
  logic           win_found;

  assign Valid          = (state_q == GRANT);
  assign Encoder_Output = enc_q;
  assign Pending        = pend_q;
  assign elig           = pend_q & ~Mask;
  assign ack_fire       = Valid & Ack;
  assign start          = ROUND_ROBIN ? ptr_q : '0;

  for (genvar g = 0; g < N; g++) begin : g_clr
    assign clr[g] = ack_fire && (enc_q == W'(g));
  end

  // Scan from the farthest offset down so the nearest set bit at/after start wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = start + W'(i);
      if (elig[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    // Set beats clear, so a re-request during Ack stays pending.
    pend_d  = (pend_q & ~clr) | (Enable ? Request_In : '0);
    state_d = state_q;
    enc_d   = enc_q;
    ptr_d   = ptr_q;
    if (Clear_All) begin
      pend_d  = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            enc_d   = win_idx;
            state_d = GRANT;
          end
        end
        GRANT: begin
          if (Ack) begin
            state_d = IDLE;
            ptr_d   = enc_q + W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      enc_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      enc_q   <= enc_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_request_encoder_16to4.sv
// Directed bench: fixed-priority instance driven from a vector table, plus
// hand sequences for the all-pending sweep and round-robin behaviour.
module tb_request_encoder_16to4;

  logic        Clock;
  logic        Reset_n;
  logic        Enable;
  logic [15:0] Request_In;
  logic [15:0] Mask;
  logic        Clear_All;
  logic        Ack;
  logic [3:0]  enc_fx, enc_rr;
  logic        vld_fx, vld_rr;
  logic [15:0] pend_fx, pend_rr;

  int n_chk = 0;
  int n_bad = 0;

  request_encoder_16to4 #(.ROUND_ROBIN(1'b0)) dut_fx (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Request_In(Request_In),
    .Mask(Mask), .Clear_All(Clear_All), .Ack(Ack),
    .Encoder_Output(enc_fx), .Valid(vld_fx), .Pending(pend_fx));

  request_encoder_16to4 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Request_In(Request_In),
    .Mask(Mask), .Clear_All(Clear_All), .Ack(Ack),
    .Encoder_Output(enc_rr), .Valid(vld_rr), .Pending(pend_rr));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic [15:0] mask;
    logic        clr;
    logic        ack;
    logic        v;
    logic [3:0]  idx;
    logic [15:0] pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic [15:0] req, input logic [15:0] mask,
                     input logic clr, input logic ack, input logic v,
                     input logic [3:0] idx, input logic [15:0] pend);
    vec_t r;
    r.en = en; r.req = req; r.mask = mask; r.clr = clr; r.ack = ack;
    r.v = v; r.idx = idx; r.pend = pend;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [15:0] req, input logic [15:0] mask,
                       input logic clr, input logic ack);
    Enable = en; Request_In = req; Mask = mask; Clear_All = clr; Ack = ack;
  endtask

  int exp_rr[4] = '{0, 4, 0, 4};

  initial begin
    // Reset with requests held: nothing may be captured.
    Reset_n = 1'b0;
    drive(1'b1, 16'h8001, 16'h0000, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_pend_fx", 32'(pend_fx), 32'h0);
    chk("rst_vld_fx",  32'(vld_fx),  32'h0);
    chk("rst_pend_rr", 32'(pend_rr), 32'h0);
    chk("rst_vld_rr",  32'(vld_rr),  32'h0);
    Reset_n = 1'b1;

    //   en    req       mask      clr   ack   v     idx   pend
    add(1'b1, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h8001);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0,  16'h8001);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h8000);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd15, 16'h8000);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000);
    // back-to-back acks on 0A50
    add(1'b1, 16'h0A50, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0A50);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd4,  16'h0A50);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0A40);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd6,  16'h0A40);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0A00);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd9,  16'h0A00);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0800);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd11, 16'h0800);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000);
    // re-request of bit 3 during its ack
    add(1'b1, 16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0008);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0008);
    add(1'b1, 16'h0008, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0008);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0008);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000);
    // masking: pending retained, grant only once unmasked, mask change ignored in GRANT
    add(1'b1, 16'h0006, 16'hFFFE, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0006);
    add(1'b1, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0006);
    add(1'b1, 16'h0000, 16'hFFF9, 1'b0, 1'b0, 1'b1, 4'd1,  16'h0006);
    add(1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'd1,  16'h0006);
    add(1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0004);
    add(1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0004);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd2,  16'h0004);
    // Clear_All during GRANT with Ack and a new request
    add(1'b1, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000);
    // Enable=0 during GRANT blocks capture only
    add(1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0020);
    add(1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd5,  16'h0020);
    add(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000);

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].req, tbl[k].mask, tbl[k].clr, tbl[k].ack);
      tick();
      chk($sformatf("vec%0d_valid", k), 32'(vld_fx), 32'(tbl[k].v));
      if (tbl[k].v) chk($sformatf("vec%0d_idx", k), 32'(enc_fx), 32'(tbl[k].idx));
      chk($sformatf("vec%0d_pend", k), 32'(pend_fx), 32'(tbl[k].pend));
    end

    // All 16 pending, fixed priority: strict 0..15 order
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("all16_pend", 32'(pend_fx), 32'hFFFF);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
      chk($sformatf("all16_idx%0d", i), 32'(enc_fx), 32'(i));
      chk($sformatf("all16_vld%0d", i), 32'(vld_fx), 32'h1);
      drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
      tick();
      chk($sformatf("all16_drop%0d", i), 32'(vld_fx), 32'h0);
    end
    chk("all16_empty", 32'(pend_fx), 32'h0);

    // Round-robin: re-pulse the granted bit on each ack
    drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    drive(1'b1, 16'h0011, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("rr_pend0", 32'(pend_rr), 32'h0011);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
      chk($sformatf("rr_vld%0d", k), 32'(vld_rr), 32'h1);
      chk($sformatf("rr_idx%0d", k), 32'(enc_rr), 32'(exp_rr[k]));
      drive(1'b1, 16'h0001 << exp_rr[k], 16'h0000, 1'b0, 1'b1);
      tick();
      chk($sformatf("rr_drop%0d", k), 32'(vld_rr), 32'h0);
      chk($sformatf("rr_pend%0d", k), 32'(pend_rr), 32'h0011);
    end

    // Clear_All keeps the pointer (now 5): bits 0 and 5 -> 5 wins, then wrap to 0
    drive(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tick();
    chk("rr_clr_pend", 32'(pend_rr), 32'h0);
    chk("rr_clr_vld",  32'(vld_rr),  32'h0);
    drive(1'b1, 16'h0021, 16'h0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("rr_ptr_kept", 32'(enc_rr), 32'h5);
    drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("rr_wrap_idx", 32'(enc_rr), 32'h0);
    chk("rr_wrap_vld", 32'(vld_rr), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
